// File: rtl/mc_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath, with single-step gating
// and a retired-instruction counter for board debug.
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             step_mode,
  input  logic             step,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUSel,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] PC_ALU_RES = 2'd0;
  localparam logic [1:0] PC_ALU_OUT = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       illegal;
  } ctrl_t;

  // Returns {supported, alu_sel} for an R-type function field.
  function automatic logic [3:0] decode_func(input logic [5:0] f);
    case (f)
      6'h20:   decode_func = {1'b1, ALU_ADD};
      6'h22:   decode_func = {1'b1, ALU_SUB};
      6'h24:   decode_func = {1'b1, ALU_AND};
      6'h25:   decode_func = {1'b1, ALU_OR};
      6'h2A:   decode_func = {1'b1, ALU_SLT};
      default: decode_func = {1'b0, ALU_AND};
    endcase
  endfunction

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic       step_q;
  logic       step_edge;
  logic       retire;
  logic [3:0] func_dec;

  assign step_edge = step & ~step_q;
  assign func_dec  = decode_func(func);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // In single-step mode, FETCH idles with all strobes low until a fresh press.
        if (!step_mode || step_edge) begin
          ctrl.mem_read  = 1'b1;
          ctrl.ir_write  = 1'b1;
          ctrl.pc_en     = 1'b1;
          ctrl.alu_src_b = SRCB_ONE;
          ctrl.alu_sel   = ALU_ADD;
          ctrl.pc_source = PC_ALU_RES;
          state_d        = S_DECODE;
        end
      end

      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_sel   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_sel   = ALU_ADD;
        state_d        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        state_d       = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end

      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_sel   = func_dec[2:0];
        if (func_dec[3]) begin
          state_d = S_ALUWB;
        end else begin
          ctrl.illegal = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_sel   = ALU_SUB;
        ctrl.pc_source = PC_ALU_OUT;
        ctrl.pc_en     = zero;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_source = PC_JUMP;
        ctrl.pc_en     = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_sel   = ALU_ADD;
        state_d        = S_ADDIWB;
      end

      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Reset kills any write the aborted instruction would have issued.
    if (rst) begin
      ctrl   = '0;
      retire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_FETCH;
      step_q    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign PCEn      = ctrl.pc_en;
  assign IorD      = ctrl.i_or_d;
  assign MemRead   = ctrl.mem_read;
  assign MemWrite  = ctrl.mem_write;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign IRWrite   = ctrl.ir_write;
  assign RegWrite  = ctrl.reg_write;
  assign RegDst    = ctrl.reg_dst;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign PCSource  = ctrl.pc_source;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUSel    = ctrl.alu_sel;
  assign illegal   = ctrl.illegal;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: an instruction-level model expands
// each instruction into its per-cycle control vectors, checked every cycle.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst, zero, step_mode, step;
  logic [5:0]  opcode, func;
  logic        PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  PCSource, ALUSrcB;
  logic [2:0]  ALUSel;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_cnt;

  mc_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .step_mode(step_mode), .step(step),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUSel(ALUSel),
    .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_sel;
    logic       illegal;
  } obs_t;

  typedef struct {
    obs_t        v;
    logic [31:0] cnt;
  } exp_t;

  obs_t        dut_v;
  exp_t        exp_q[$];
  logic [3:0]  st_log[$];
  logic [31:0] m_cnt = 0;
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, rw_n = 0, ill_n = 0;

  assign dut_v = {state, PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst,
                  ALUSrcA, PCSource, ALUSrcB, ALUSel, illegal};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Single compare process: one expected vector per cycle while any are queued.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("outputs", 64'(dut_v), 64'(e.v));
      check("instr_cnt", 64'(instr_cnt), 64'(e.cnt));
      st_log.push_back(state);
      cyc++;
      if (RegWrite) rw_n++;
      if (illegal) ill_n++;
    end
  end

  function automatic obs_t rec(input logic [3:0] st);
    obs_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  task automatic push(input obs_t v);
    exp_t e;
    e.v   = v;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Expands one instruction into the cycle-by-cycle control vectors it must produce.
  task automatic push_instr(input logic [31:0] w, input logic z, input int limit);
    obs_t       r[$];
    obs_t       v;
    logic [5:0] op, fn;
    logic [2:0] sel;
    bit         ok, retires;
    op = w[31:26];
    fn = w[5:0];
    retires = 0;

    v = rec(4'd0); v.mem_read = 1; v.ir_write = 1; v.pcen = 1; v.alu_src_b = 2'd1; v.alu_sel = ADD;
    r.push_back(v);
    v = rec(4'd1); v.alu_src_b = 2'd2; v.alu_sel = ADD;
    if (!(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08})) begin
      v.illegal = 1;
      r.push_back(v);
    end else begin
      r.push_back(v);
      case (op)
        6'h23, 6'h2B: begin
          v = rec(4'd2); v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_sel = ADD; r.push_back(v);
          if (op == 6'h23) begin
            v = rec(4'd3); v.mem_read = 1; v.iord = 1; r.push_back(v);
            v = rec(4'd4); v.reg_write = 1; v.mem_to_reg = 1; r.push_back(v);
          end else begin
            v = rec(4'd5); v.mem_write = 1; v.iord = 1; r.push_back(v);
          end
          retires = 1;
        end
        6'h00: begin
          ok = 1;
          case (fn)
            6'h20: sel = ADD;
            6'h22: sel = SUB;
            6'h24: sel = AND_;
            6'h25: sel = OR_;
            6'h2A: sel = SLT;
            default: begin sel = 3'b000; ok = 0; end
          endcase
          v = rec(4'd6); v.alu_src_a = 1; v.alu_sel = sel; v.illegal = !ok; r.push_back(v);
          if (ok) begin
            v = rec(4'd7); v.reg_write = 1; v.reg_dst = 1; r.push_back(v);
            retires = 1;
          end
        end
        6'h04: begin
          v = rec(4'd8); v.alu_src_a = 1; v.alu_sel = SUB; v.pc_source = 2'd1; v.pcen = z;
          r.push_back(v);
          retires = 1;
        end
        6'h02: begin
          v = rec(4'd9); v.pc_source = 2'd2; v.pcen = 1; r.push_back(v);
          retires = 1;
        end
        default: begin
          v = rec(4'd10); v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_sel = ADD; r.push_back(v);
          v = rec(4'd11); v.reg_write = 1; r.push_back(v);
          retires = 1;
        end
      endcase
    end
    for (int i = 0; i < r.size() && (limit < 0 || i < limit); i++) push(r[i]);
    if (retires && (limit < 0 || limit >= r.size())) m_cnt++;
  endtask

  // Waits (bounded) until every queued vector has been checked; returns 1 ns after a posedge.
  task automatic drain();
    int g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (exp_q.size() != 0 && g < 200);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    #1;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic z, input int limit = -1);
    opcode = w[31:26];
    func   = w[5:0];
    zero   = z;
    push_instr(w, z, limit);
    drain();
  endtask

  task automatic run_stall(input int n);
    repeat (n) push(rec(4'd0));
    drain();
  endtask

  task automatic clear_logs();
    st_log.delete();
    cyc = 0;
    rw_n = 0;
    ill_n = 0;
  endtask

  logic [3:0] seq2 [8] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd6, 4'd7};

  initial begin
    rst = 1; zero = 0; step_mode = 0; step = 0; opcode = 6'h00; func = 6'h00;
    repeat (2) begin
      @(negedge clk);
      check("rst_ctrl_init", 64'(dut_v[16:0]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 0;
    check("init_state", 64'(state), 64'd0);
    check("init_cnt", 64'(instr_cnt), 64'd0);

    // addi then add
    clear_logs();
    run_instr(32'h20100005, 1'b0);
    run_instr(32'h02309020, 1'b0);
    check("t2_cycles", 64'(cyc), 64'd8);
    check("t2_cnt", 64'(instr_cnt), 64'd2);
    check("t2_regwrite_cycles", 64'(rw_n), 64'd2);
    check("t2_seq_len", 64'(st_log.size()), 64'd8);
    if (st_log.size() == 8)
      for (int i = 0; i < 8; i++) check($sformatf("t2_seq%0d", i), 64'(st_log[i]), 64'(seq2[i]));

    // lw then sw
    clear_logs();
    run_instr(32'h8C080004, 1'b0);
    run_instr(32'hAC080008, 1'b0);
    check("t3_cycles", 64'(cyc), 64'd9);
    check("t3_cnt", 64'(instr_cnt), 64'd4);

    // beq taken, beq not taken, jump
    clear_logs();
    run_instr(32'h1109FFFE, 1'b1);
    run_instr(32'h1109FFFE, 1'b0);
    run_instr(32'h08000010, 1'b0);
    check("t4_cycles", 64'(cyc), 64'd9);
    check("t4_cnt", 64'(instr_cnt), 64'd7);

    // unsupported opcode and unsupported function
    clear_logs();
    run_instr(32'hFC000000, 1'b0);
    run_instr(32'h00000000, 1'b0);
    check("t5_cycles", 64'(cyc), 64'd5);
    check("t5_illegal_pulses", 64'(ill_n), 64'd2);
    check("t5_cnt", 64'(instr_cnt), 64'd7);

    // remaining ALU functions
    run_instr(32'h02309022, 1'b0);
    run_instr(32'h02309024, 1'b0);
    run_instr(32'h02309025, 1'b0);
    run_instr(32'h0230902A, 1'b0);
    check("alu_cnt", 64'(instr_cnt), 64'd11);

    // reset while an add sits in ALUWB
    run_instr(32'h02309020, 1'b0, 3);
    check("t1_pre_state", 64'(state), 64'd7);
    rst = 1;
    @(negedge clk);
    check("t1_rst_ctrl0", 64'(dut_v[16:0]), 64'd0);
    @(posedge clk); #1;
    check("t1_rst_state", 64'(state), 64'd0);
    @(negedge clk);
    check("t1_rst_ctrl1", 64'(dut_v[16:0]), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    m_cnt = 0;
    check("t1_state", 64'(state), 64'd0);
    check("t1_cnt", 64'(instr_cnt), 64'd0);

    // single-step: held button issues exactly one instruction
    step_mode = 1;
    run_stall(3);
    step = 1;
    run_instr(32'h20100005, 1'b0);
    run_stall(16);
    check("t6_held_cnt", 64'(instr_cnt), 64'd1);
    step = 0;
    run_stall(2);
    step = 1;
    run_instr(32'h08000010, 1'b0);
    step = 0;
    run_stall(2);
    check("t6_second_cnt", 64'(instr_cnt), 64'd2);
    step_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
